pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline control unit for the five-stage MIPS core. It drives the stall, bubble and flush inputs of the IF/ID and ID/EX pipeline registers. It combines Tuse/Tnew data-hazard detection, a multiply/divide busy counter, and a two-state flush sequencer for exceptions and `eret`. It sits beside the decode stage and receives hazard information from EX and MEM and exception requests from CP0 in MEM.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start
- DIV_CYC, 10, busy cycles after a div/divu start
- HANDLER_PC, 32'h0000_4180, exception vector, reported for debug only

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rs, id_rt  in  5 each  ID source registers
- id_tuse_rs, id_tuse_rt  in  2 each  Tuse of each source; 3 = not used
- id_is_md  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- ex_dst, mem_dst  in  5 each  destination register in EX / MEM; 0 = none
- ex_tnew, mem_tnew  in  3 each  remaining Tnew in EX / MEM
- ex_md_start  in  1  EX starts an MDU operation this cycle
- ex_md_is_div  in  1  qualifies ex_md_start; 1 = divide
- exc_req  in  1  CP0 takes an exception (MEM stage)
- eret_req  in  1  eret in MEM
- stall  out  1  freeze PC and IF/ID
- clear_idex  out  1  insert a bubble into ID/EX
- clear_all  out  1  flush IF/ID, ID/EX, EX/MEM
- redirect_sel  out  2  PC source: 0 sequential, 1 HANDLER_PC, 2 EPC
- md_busy  out  1  MDU counter nonzero

## Operation
- **Data hazard**, combinational:
  - rs_hz = rs≠0 & ((rs==ex_dst & tuse_rs<ex_tnew) | (rs==mem_dst & tuse_rs<mem_tnew)).
  - rt_hz is the same check for rt.
  - tuse=3 never hazards.
- **MDU hazard**: md_hz = id_is_md & (md_busy | ex_md_start).
- **Raw stall**: raw = rs_hz | rt_hz | md_hz.
- **MDU counter**, 4-bit:
  - On ex_md_start in RUN, load DIV_CYC or MULT_CYC.
  - Otherwise decrement while nonzero.
  - md_busy = (cnt≠0).
  - ex_md_start while busy is ignored.
- **Flush FSM**:
  - RUN → FLUSH on exc_req | eret_req.
  - When flush is entered, latch redirect_sel = 1 if exc_req, else 2. Exception wins if both are high.
  - FLUSH → RUN after exactly one cycle, unless exc_req or eret_req is high again; then stay in FLUSH and re-latch redirect_sel.
  - In FLUSH:
    - clear_all=1.
    - stall=0 and clear_idex=0; flush overrides stall.
    - MDU counter cleared to 0.
    - redirect_sel holds the latched value.
  - In RUN: clear_all=0, redirect_sel=0, stall=raw, clear_idex=raw.
- Width rule: the counter parameters must be ≤ 15; elaboration fails otherwise.

## Timing
- Reset values: state RUN, counter 0, stall=0, clear_idex=0, clear_all=0, redirect_sel=0, md_busy=0.
- stall and clear_idex are combinational from the ID/EX/MEM inputs in the same cycle, gated by the registered state.
- clear_all and redirect_sel are registered. The exception is seen at edge N, and clear_all plus redirect are high during cycle N+1.
- MDU latency:
  - ex_md_start high at edge N → md_busy high for cycles N+1 … N+MULT_CYC (or N+DIV_CYC).
  - md_busy is low from the next cycle onward.
- A reset mid-flush or mid-MDU returns everything to its reset values at the next edge.

## Configuration
- Macro: PIPE_HAZARD_CTRL_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0], which increments each cycle with stall=1 and saturates at 32'hFFFF_FFFF.
  - stall_cnt resets to 0 and is not affected by flushes.
- When undefined: the port and the counter do not exist, and all other behaviour is identical.

## Test plan
- **Load-use**: id_rs=8, tuse_rs=0, ex_dst=8, ex_tnew=2 → stall=1, clear_idex=1. With ex_tnew=0 → stall=0. With rs=0 → stall=0.
- **MEM forward boundary**: id_rt=5, tuse_rt=1, mem_dst=5, mem_tnew=1 → stall=0. With mem_tnew=2 → stall=1.
- **Divide**: ex_md_start=1, ex_md_is_div=1 at edge 0 → md_busy high for cycles 1–10, low at cycle 11. id_is_md=1 during that window → stall=1 throughout.
- **Exception while a stall is pending**: raw=1 and exc_req=1 at edge N → cycle N+1 has clear_all=1, redirect_sel=1, stall=0, md_busy=0. Cycle N+2 is back in RUN.
- **exc_req and eret_req together** → redirect_sel=1. eret alone → redirect_sel=2.
- **Back-to-back exc_req** on two consecutive edges → clear_all stays high for 2 cycles. Then assert reset mid-flush → all outputs 0 after the edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble/flush control for the five-stage MIPS pipeline
// Optional stall counter output enabled by PIPE_HAZARD_CTRL_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int          MULT_CYC   = 5,
  parameter int          DIV_CYC    = 10,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [1:0]  id_tuse_rs,
  input  logic [1:0]  id_tuse_rt,
  input  logic        id_is_md,
  input  logic [4:0]  ex_dst,
  input  logic [4:0]  mem_dst,
  input  logic [2:0]  ex_tnew,
  input  logic [2:0]  mem_tnew,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic        exc_req,
  input  logic        eret_req,
  output logic        stall,
  output logic        clear_idex,
  output logic        clear_all,
  output logic [1:0]  redirect_sel,
  output logic        md_busy
`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  // The busy counter is 4 bits wide and the vector must be word aligned.
  if (MULT_CYC < 0 || MULT_CYC > 15 || DIV_CYC < 0 || DIV_CYC > 15) begin : g_bad_cyc
    $error("pipe_hazard_ctrl: MULT_CYC/DIV_CYC must be in 0..15");
  end
  if (HANDLER_PC[1:0] != 2'b00) begin : g_bad_vec
    $error("pipe_hazard_ctrl: HANDLER_PC must be word aligned");
  end

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state, state_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  logic       rs_hz, rt_hz, md_hz, raw, flush_req;

  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] e_dst, input logic [2:0] e_tnew,
                                      input logic [4:0] m_dst, input logic [2:0] m_tnew);
    logic [2:0] t;
    t = {1'b0, tuse};
    return (src != 5'd0) && (tuse != 2'd3) &&
           (((src == e_dst) && (t < e_tnew)) || ((src == m_dst) && (t < m_tnew)));
  endfunction

  assign rs_hz     = src_hazard(id_rs, id_tuse_rs, ex_dst, ex_tnew, mem_dst, mem_tnew);
  assign rt_hz     = src_hazard(id_rt, id_tuse_rt, ex_dst, ex_tnew, mem_dst, mem_tnew);
  assign md_busy   = (cnt_q != 4'd0);
  assign md_hz     = id_is_md && (md_busy || ex_md_start);
  assign raw       = rs_hz || rt_hz || md_hz;
  assign flush_req = exc_req || eret_req;

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel_q;
    cnt_nxt      = cnt_q;
    stall        = 1'b0;
    clear_idex   = 1'b0;
    clear_all    = 1'b0;
    redirect_sel = 2'd0;
    case (state)
      RUN: begin
        stall      = raw;
        clear_idex = raw;
        if (ex_md_start && !md_busy)
          cnt_nxt = ex_md_is_div ? DIV_LD : MULT_LD;
        else if (md_busy)
          cnt_nxt = cnt_q - 4'd1;
      end
      FLUSH: begin
        clear_all    = 1'b1;
        redirect_sel = sel_q;
        cnt_nxt      = 4'd0;
        state_nxt    = RUN;
      end
      default: state_nxt = RUN;
    endcase
    // A new request re-enters (or stays in) FLUSH; exception beats eret.
    if (flush_req) begin
      state_nxt = FLUSH;
      sel_nxt   = exc_req ? 2'd1 : 2'd2;
      cnt_nxt   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      sel_q <= 2'd0;
      cnt_q <= 4'd0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      cnt_q <= cnt_nxt;
    end
  end

`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= 32'd0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
